// File: rtl/msfsm_cfg_loader_if.sv
// Host-side configuration word stream: valid/ready with last-word marker.
interface msfsm_cfg_loader_if #(
    parameter int unsigned WORD_W = 8
) ();
    logic              cfg_valid;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_last;
    logic              cfg_ready;

    modport master (output cfg_valid, output cfg_data, output cfg_last, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_data, input cfg_last, output cfg_ready);
endinterface

// File: rtl/msfsm_cfg_loader.sv
// Serial configuration loader: takes host words over a valid/ready stream,
// holds the FSM wrapper in reset, shifts CFG_BITS bits LSB-first, then
// releases reset and reports completion. Framing errors abort the load.
module msfsm_cfg_loader #(
    parameter int unsigned CFG_BITS   = 64,
    parameter int unsigned WORD_W     = 8,
    parameter int unsigned CLR_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    msfsm_cfg_loader_if.slave    cfg,
    output logic                 fsm_sreset,
    output logic                 fsm_en,
    output logic                 fsm_d,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 configured
);
    localparam int unsigned NWORDS    = (CFG_BITS + WORD_W - 1) / WORD_W;
    localparam int unsigned LAST_BITS = CFG_BITS - (NWORDS - 1) * WORD_W;
    localparam int unsigned BC_W      = $clog2(WORD_W + 1);
    localparam int unsigned WC_W      = $clog2(NWORDS + 1);
    localparam int unsigned EC_W      = $clog2(CFG_BITS + 1);
    localparam int unsigned CC_W      = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DONE,
        S_ABORT
    } state_e;

    state_e            state_q, state_d;
    logic [CC_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [WC_W-1:0]   words_q, words_d;
    logic [EC_W-1:0]   emitted_q, emitted_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              hold_last_q, hold_last_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic [BC_W-1:0]   sr_cnt_q, sr_cnt_d;
    logic              fsm_sreset_q, fsm_sreset_d;
    logic              fsm_en_q, fsm_en_d;
    logic              fsm_d_q, fsm_d_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              configured_q, configured_d;

    logic              ready;
    logic              accept;
    logic              is_final;
    logic              emit;
    logic              emit_bit;
    logic [BC_W-1:0]   hold_bits;

    assign ready = ((state_q == S_CLEAR) || (state_q == S_SHIFT)) && !hold_full_q
                   && (words_q < WC_W'(NWORDS));
    assign accept    = ready && cfg.cfg_valid;
    assign is_final  = (words_q == WC_W'(NWORDS - 1));
    assign hold_bits = hold_last_q ? BC_W'(LAST_BITS) : BC_W'(WORD_W);

    assign cfg.cfg_ready = ready;
    assign fsm_sreset    = fsm_sreset_q;
    assign fsm_en        = fsm_en_q;
    assign fsm_d         = fsm_d_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign configured    = configured_q;

    // Next state, word intake, bit emission and registered output values
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        words_d     = words_q;
        emitted_d   = emitted_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        hold_last_d = hold_last_q;
        sr_d        = sr_q;
        sr_cnt_d    = sr_cnt_q;
        err_d       = err_q;
        emit        = 1'b0;
        emit_bit    = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE, S_ABORT: begin
                if (start) begin
                    state_d     = S_CLEAR;
                    err_d       = 1'b0;
                    clr_cnt_d   = '0;
                    words_d     = '0;
                    emitted_d   = '0;
                    hold_full_d = 1'b0;
                    sr_cnt_d    = '0;
                end
            end
            S_CLEAR: begin
                if (clr_cnt_q == CC_W'(CLR_CYCLES - 1)) state_d = S_SHIFT;
                else                                    clr_cnt_d = clr_cnt_q + CC_W'(1);
            end
            S_SHIFT: begin
                if (emitted_q == EC_W'(CFG_BITS)) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // A word whose cfg_last disagrees with its position aborts the load
        // and is never placed in the holding register.
        if (accept) begin
            if (cfg.cfg_last != is_final) begin
                state_d = S_ABORT;
                err_d   = 1'b1;
            end else begin
                hold_d      = cfg.cfg_data;
                hold_full_d = 1'b1;
                hold_last_d = cfg.cfg_last;
                words_d     = words_q + WC_W'(1);
            end
        end

        // Emission is decided one edge early so fsm_en/fsm_d are registered;
        // the holding word refills the shifter while its last bit goes out.
        if (state_d == S_SHIFT) begin
            if (sr_cnt_q != '0) begin
                emit     = 1'b1;
                emit_bit = sr_q[0];
                sr_d     = sr_q >> 1;
                sr_cnt_d = sr_cnt_q - BC_W'(1);
                if ((sr_cnt_q == BC_W'(1)) && hold_full_q) begin
                    sr_d        = hold_q;
                    sr_cnt_d    = hold_bits;
                    hold_full_d = 1'b0;
                end
            end else if (hold_full_q) begin
                emit        = 1'b1;
                emit_bit    = hold_q[0];
                sr_d        = hold_q >> 1;
                sr_cnt_d    = hold_bits - BC_W'(1);
                hold_full_d = 1'b0;
            end
        end

        if (emit) emitted_d = emitted_q + EC_W'(1);

        fsm_en_d     = emit;
        fsm_d_d      = emit ? emit_bit : fsm_d_q;
        busy_d       = (state_d == S_CLEAR) || (state_d == S_SHIFT);
        fsm_sreset_d = (state_d != S_DONE);
        configured_d = (state_d == S_DONE);
        done_d       = (state_q != S_DONE) && (state_d == S_DONE);
    end

    // State and output registers; asynchronous reset forces FSMs into reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            clr_cnt_q    <= '0;
            words_q      <= '0;
            emitted_q    <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            hold_last_q  <= 1'b0;
            sr_q         <= '0;
            sr_cnt_q     <= '0;
            fsm_sreset_q <= 1'b1;
            fsm_en_q     <= 1'b0;
            fsm_d_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            configured_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            words_q      <= words_d;
            emitted_q    <= emitted_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            hold_last_q  <= hold_last_d;
            sr_q         <= sr_d;
            sr_cnt_q     <= sr_cnt_d;
            fsm_sreset_q <= fsm_sreset_d;
            fsm_en_q     <= fsm_en_d;
            fsm_d_q      <= fsm_d_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            configured_q <= configured_d;
        end
    end
endmodule
